rom_banked_pipelined: RTL

//  Parametrised, bank-switched program ROM for the 6502 memory map; next generation of the 16Kx8 ROM model.

---
 rtl/rom_pkg.sv | 14 +
 rtl/rom_read_pipe.sv | 41 ++++
 rtl/rom_banked_pipelined.sv | 127 ++++++++++++
 3 files changed

// File: rtl/rom_pkg.sv
// rtl/rom_pkg.sv - shared types, limits and sizing helper for the banked program ROM
package rom_pkg;

   typedef enum logic {ROM_LOAD, ROM_RUN} rom_state_t;

   localparam int MAX_LATENCY = 4;
   localparam int MAX_BANKS   = 16;

   // A single-bank ROM still carries one (always zero) bank bit so vectors never go zero-width.
   function automatic int bank_bits(input int banks);
      return (banks > 1) ? $clog2(banks) : 1;
   endfunction

endpackage

// File: rtl/rom_read_pipe.sv
// rtl/rom_read_pipe.sv - valid/data shift stages; stage 0 registers the array read
module rom_read_pipe #(
   parameter int DATA_W  = 8,
   parameter int LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data
);

   logic [LATENCY-1:0] valid_q, valid_d;
   logic [DATA_W-1:0]  data_q [LATENCY];
   logic [DATA_W-1:0]  data_d [LATENCY];

   // Data only advances alongside a valid beat, so the last stage holds between reads.
   always_comb begin
      valid_d[0] = in_valid;
      data_d[0]  = in_valid ? in_data : data_q[0];
      for (int i = 1; i < LATENCY; i++) begin
         valid_d[i] = valid_q[i-1];
         data_d[i]  = valid_q[i-1] ? data_q[i-1] : data_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         data_q  <= '{default: '0};
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q[LATENCY-1];
   assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/rom_banked_pipelined.sv
// rtl/rom_banked_pipelined.sv - bank-switched program ROM with load phase and fixed-latency reads
module rom_banked_pipelined
   import rom_pkg::*;
#(
   parameter int    ADDR_W       = 14,
   parameter int    DATA_W       = 8,
   parameter int    BANKS        = 1,
   parameter int    LATENCY      = 1,
   parameter string INIT_FILE    = "",
   parameter bit    START_LOCKED = 1'b0
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  cs_b,
   input  logic                                  oe_b,
   input  logic [ADDR_W-1:0]                     addr,
   output logic [DATA_W-1:0]                     dout,
   output logic                                  dout_valid,
   output logic                                  dout_oe,
   input  logic                                  bank_we,
   input  logic [3:0]                            bank_wdata,
   input  logic                                  prog_we,
   input  logic [ADDR_W+bank_bits(BANKS)-1:0]    prog_addr,
   input  logic [DATA_W-1:0]                     prog_data,
   input  logic                                  prog_done,
   output logic                                  ready,
   output logic                                  err
);

   localparam int BB    = bank_bits(BANKS);
   localparam int PA_W  = ADDR_W + BB;
   localparam int EA_W  = ADDR_W + ((BANKS > 1) ? $clog2(BANKS) : 0);
   localparam int DEPTH = BANKS << ADDR_W;
   localparam logic [PA_W:0] DEPTH_L = (PA_W + 1)'(DEPTH);
   localparam logic [4:0]    BANKS_L = 5'(BANKS);

   generate
      if (BANKS < 1 || BANKS > MAX_BANKS) begin : g_bad_banks
         $error("rom_banked_pipelined: BANKS out of range 1..16");
      end
      if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
         $error("rom_banked_pipelined: LATENCY out of range 1..4");
      end
   endgenerate

   logic [DATA_W-1:0] mem [DEPTH];

   rom_state_t      state_q, state_d;
   logic [BB-1:0]   bank_q, bank_d;
   logic            err_q, err_d;
   logic            ready_q, ready_d;
   logic            bank_ok;
   logic            mem_we;
   logic            rd_req;
   logic [EA_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;

   generate
      if (BANKS > 1) begin : g_multi
         assign rd_addr = {bank_q, addr};
      end else begin : g_single
         logic unused_bank;
         assign rd_addr     = addr;
         assign unused_bank = ^bank_q;
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      bank_d  = bank_q;
      err_d   = err_q;
      bank_ok = ({1'b0, bank_wdata} < BANKS_L);
      if (state_q == ROM_LOAD && prog_done) begin
         state_d = ROM_RUN;
      end
      if (bank_we && bank_ok) begin
         bank_d = bank_wdata[BB-1:0];
      end
      // Both error sources fold into one sticky bit; it only ever goes high here.
      if ((bank_we && !bank_ok) || (prog_we && state_q == ROM_RUN)) begin
         err_d = 1'b1;
      end
      ready_d = (state_d == ROM_RUN);
      mem_we  = !rst && prog_we && state_q == ROM_LOAD && ({1'b0, prog_addr} < DEPTH_L);
      rd_req  = state_q == ROM_RUN && !cs_b && !oe_b;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= START_LOCKED ? ROM_RUN : ROM_LOAD;
         bank_q  <= '0;
         err_q   <= 1'b0;
         ready_q <= START_LOCKED;
      end else begin
         state_q <= state_d;
         bank_q  <= bank_d;
         err_q   <= err_d;
         ready_q <= ready_d;
      end
   end

   // Array contents survive reset, so the write port has no reset branch.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[prog_addr[EA_W-1:0]] <= prog_data;
      end
   end

   assign rd_data = mem[rd_addr];

   rom_read_pipe #(
      .DATA_W  (DATA_W),
      .LATENCY (LATENCY)
   ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (rd_req),
      .in_data   (rd_data),
      .out_valid (dout_valid),
      .out_data  (dout)
   );

   assign dout_oe = dout_valid;
   assign ready   = ready_q;
   assign err     = err_q;

endmodule
